// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine feeding the VGA framebuffer write port.
// Single-cell MCU writes always take the port; fill writes stall around them.
module vga_rect_fill #(
    parameter int COLS = 80,
    parameter int ROWS = 60
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [6:0]  X0,
    input  logic [5:0]  Y0,
    input  logic [6:0]  X1,
    input  logic [5:0]  Y1,
    input  logic [7:0]  COLOR,
    input  logic [12:0] CPU_WA,
    input  logic [7:0]  CPU_WD,
    input  logic        CPU_WE,
    output logic [12:0] WA,
    output logic [7:0]  WD,
    output logic        WE,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [6:0] XLIM = 7'(COLS - 1);
    localparam logic [5:0] YLIM = 6'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t      state_q;

    // Raw corners as latched on START; clamping happens in SETUP.
    logic [6:0]  cx_q [2];
    logic [5:0]  cy_q [2];
    logic [7:0]  color_q;

    logic [6:0]  xmin_q, xmax_q, x_q;
    logic [5:0]  ymin_q, ymax_q, y_q;

    logic [12:0] wa_q;
    logic [7:0]  wd_q;
    logic        we_q;
    logic        busy_q;
    logic        done_q;

    logic [6:0]  cx_clamp_d [2];
    logic [5:0]  cy_clamp_d [2];
    logic [6:0]  xmin_d, xmax_d;
    logic [5:0]  ymin_d, ymax_d;
    logic        row_end_d;
    logic        last_cell_d;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
            assign cx_clamp_d[gi] = (cx_q[gi] > XLIM) ? XLIM : cx_q[gi];
            assign cy_clamp_d[gi] = (cy_q[gi] > YLIM) ? YLIM : cy_q[gi];
        end
    endgenerate

    assign xmin_d = (cx_clamp_d[0] < cx_clamp_d[1]) ? cx_clamp_d[0] : cx_clamp_d[1];
    assign xmax_d = (cx_clamp_d[0] < cx_clamp_d[1]) ? cx_clamp_d[1] : cx_clamp_d[0];
    assign ymin_d = (cy_clamp_d[0] < cy_clamp_d[1]) ? cy_clamp_d[0] : cy_clamp_d[1];
    assign ymax_d = (cy_clamp_d[0] < cy_clamp_d[1]) ? cy_clamp_d[1] : cy_clamp_d[0];

    assign row_end_d   = (x_q == xmax_q);
    assign last_cell_d = row_end_d && (y_q == ymax_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cx_q[0] <= '0;
            cx_q[1] <= '0;
            cy_q[0] <= '0;
            cy_q[1] <= '0;
            color_q <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;

            // The MCU owns the port in any state whenever it writes.
            if (CPU_WE) begin
                we_q <= 1'b1;
                wa_q <= CPU_WA;
                wd_q <= CPU_WD;
            end

            case (state_q)
                IDLE: begin
                    if (START) begin
                        cx_q[0] <= X0;
                        cy_q[0] <= Y0;
                        cx_q[1] <= X1;
                        cy_q[1] <= Y1;
                        color_q <= COLOR;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end

                SETUP: begin
                    xmin_q  <= xmin_d;
                    xmax_q  <= xmax_d;
                    ymin_q  <= ymin_d;
                    ymax_q  <= ymax_d;
                    x_q     <= xmin_d;
                    y_q     <= ymin_d;
                    state_q <= FILL;
                end

                FILL: begin
                    // A cycle lost to the MCU holds the raster position.
                    if (!CPU_WE) begin
                        we_q <= 1'b1;
                        wa_q <= {y_q, x_q};
                        wd_q <= color_q;
                        if (last_cell_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else if (row_end_d) begin
                            x_q <= xmin_q;
                            y_q <= y_q + 6'd1;
                        end else begin
                            x_q <= x_q + 7'd1;
                        end
                    end
                end

                FIN: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WA   = wa_q;
    assign WD   = wd_q;
    assign WE   = we_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: command table plus hand sequences, with a write
// scoreboard that checks every framebuffer write against expected order.
module tb_vga_rect_fill;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [6:0]  X0 = '0;
    logic [5:0]  Y0 = '0;
    logic [6:0]  X1 = '0;
    logic [5:0]  Y1 = '0;
    logic [7:0]  COLOR = '0;
    logic [12:0] CPU_WA = '0;
    logic [7:0]  CPU_WD = '0;
    logic        CPU_WE = 1'b0;
    logic [12:0] WA;
    logic [7:0]  WD;
    logic        WE;
    logic        BUSY;
    logic        DONE;

    vga_rect_fill dut (
        .CLK(CLK), .RST(RST), .START(START),
        .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1), .COLOR(COLOR),
        .CPU_WA(CPU_WA), .CPU_WD(CPU_WD), .CPU_WE(CPU_WE),
        .WA(WA), .WD(WD), .WE(WE), .BUSY(BUSY), .DONE(DONE)
    );

    always #10 CLK = ~CLK;

    typedef struct {
        logic [12:0] wa;
        logic [7:0]  wd;
    } wr_t;

    typedef struct {
        logic [6:0]  x0;
        logic [5:0]  y0;
        logic [6:0]  x1;
        logic [5:0]  y1;
        logic [7:0]  color;
        int          stall_at;
        int          stall_len;
        bit          glitch;
        int          exp_n;
        logic [12:0] exp_last_wa;
    } vec_t;

    wr_t         fill_q[$];
    vec_t        vecs[5];
    int          n_checks = 0;
    int          n_fail = 0;
    int          fill_seen = 0;
    int          cpu_seen = 0;
    logic [12:0] last_fill_wa = '0;

    logic        cpu_exp = 1'b0;
    logic [12:0] cpu_exp_wa = '0;
    logic [7:0]  cpu_exp_wd = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // An MCU write driven at one edge must appear on the port after that edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpu_exp <= 1'b0;
        end else begin
            cpu_exp    <= CPU_WE;
            cpu_exp_wa <= CPU_WA;
            cpu_exp_wd <= CPU_WD;
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (cpu_exp) begin
                n_checks++;
                cpu_seen++;
                if (WE !== 1'b1 || WA !== cpu_exp_wa || WD !== cpu_exp_wd) begin
                    n_fail++;
                    $display("FAIL cpu_write: got WE=%b WA=0x%h WD=0x%h, want WE=1 WA=0x%h WD=0x%h",
                             WE, WA, WD, cpu_exp_wa, cpu_exp_wd);
                end else begin
                    $display("cpu write WA=0x%h WD=0x%h", WA, WD);
                end
            end else if (WE === 1'b1) begin
                n_checks++;
                if (fill_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got WA=0x%h WD=0x%h, want no write", WA, WD);
                end else begin
                    wr_t e;
                    e = fill_q.pop_front();
                    fill_seen++;
                    last_fill_wa = WA;
                    if (WA !== e.wa || WD !== e.wd) begin
                        n_fail++;
                        $display("FAIL fill_write: got WA=0x%h WD=0x%h, want WA=0x%h WD=0x%h",
                                 WA, WD, e.wa, e.wd);
                    end
                end
            end
        end
    end

    task automatic push_rect(input logic [6:0] x0, input logic [5:0] y0,
                             input logic [6:0] x1, input logic [5:0] y1, input logic [7:0] c);
        int ax0, ax1, ay0, ay1, xl, xh, yl, yh;
        ax0 = (x0 > 79) ? 79 : int'(x0);
        ax1 = (x1 > 79) ? 79 : int'(x1);
        ay0 = (y0 > 59) ? 59 : int'(y0);
        ay1 = (y1 > 59) ? 59 : int'(y1);
        xl = (ax0 < ax1) ? ax0 : ax1;
        xh = (ax0 < ax1) ? ax1 : ax0;
        yl = (ay0 < ay1) ? ay0 : ay1;
        yh = (ay0 < ay1) ? ay1 : ay0;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                wr_t w;
                w.wa = {6'(y), 7'(x)};
                w.wd = c;
                fill_q.push_back(w);
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt, busy_cnt, base_fill, base_cpu;
        bit done;
        cnt = 0;
        busy_cnt = 0;
        done = 1'b0;
        base_fill = fill_seen;
        base_cpu = cpu_seen;
        push_rect(v.x0, v.y0, v.x1, v.y1, v.color);
        @(negedge CLK);
        X0 = v.x0; Y0 = v.y0; X1 = v.x1; Y1 = v.y1; COLOR = v.color;
        START = 1'b1;
        while (cnt < 6000 && !done) begin
            @(negedge CLK);
            cnt++;
            if (cnt == 1) START = 1'b0;
            if (DONE === 1'b1) begin
                done = 1'b1;
                check("busy_at_done", 32'(BUSY), 32'd0);
            end else if (BUSY === 1'b1) begin
                busy_cnt++;
            end
            if (v.stall_len > 0 && cnt == v.stall_at) begin
                CPU_WE = 1'b1; CPU_WA = 13'h0000; CPU_WD = 8'h03;
            end
            if (v.stall_len > 0 && cnt == v.stall_at + v.stall_len) CPU_WE = 1'b0;
            if (v.glitch && cnt == 3) begin
                START = 1'b1; X0 = 7'd0; Y0 = 6'd0; X1 = 7'd9; Y1 = 6'd9; COLOR = 8'hFF;
            end
            if (v.glitch && cnt == 4) START = 1'b0;
            if (v.glitch && done) begin
                START = 1'b1; X0 = 7'd70; Y0 = 6'd50; X1 = 7'd60; Y1 = 6'd40; COLOR = 8'hAA;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE after %0d cycles, want DONE", cnt);
        end
        check("done_latency", 32'(cnt), 32'(2 + v.exp_n + v.stall_len));
        check("busy_cycles", 32'(busy_cnt), 32'(1 + v.exp_n + v.stall_len));
        @(negedge CLK);
        START = 1'b0;
        check("done_pulse_width", 32'(DONE), 32'd0);
        repeat (8) @(negedge CLK);
        check("fill_count", 32'(fill_seen - base_fill), 32'(v.exp_n));
        check("last_fill_wa", 32'(last_fill_wa), 32'(v.exp_last_wa));
        check("fill_queue_empty", 32'(fill_q.size()), 32'd0);
        check("cpu_count", 32'(cpu_seen - base_cpu), 32'(v.stall_len));
        check("idle_busy", 32'(BUSY), 32'd0);
        $display("cmd %0d (%0d,%0d)-(%0d,%0d) c=0x%h: %0d fills, latency %0d",
                 idx, v.x0, v.y0, v.x1, v.y1, v.color, fill_seen - base_fill, cnt);
    endtask

    initial begin
        int cnt, base;
        vecs[0] = '{7'd5,   6'd7,  7'd5,  6'd7,  8'hE0, 0, 0, 1'b0, 1, 13'h0385};
        vecs[1] = '{7'd2,   6'd1,  7'd4,  6'd2,  8'h1C, 0, 0, 1'b0, 6, 13'h0104};
        vecs[2] = '{7'd100, 6'd63, 7'd78, 6'd58, 8'h55, 0, 0, 1'b0, 4, 13'h1DCF};
        vecs[3] = '{7'd10,  6'd20, 7'd12, 6'd21, 8'h0F, 2, 2, 1'b0, 6, 13'h0A8C};
        vecs[4] = '{7'd4,   6'd3,  7'd1,  6'd3,  8'h92, 0, 0, 1'b1, 4, 13'h0184};

        repeat (2) @(posedge CLK);
        #1;
        check("rst_WE", 32'(WE), 32'd0);
        check("rst_WA", 32'(WA), 32'd0);
        check("rst_WD", 32'(WD), 32'd0);
        check("rst_BUSY", 32'(BUSY), 32'd0);
        check("rst_DONE", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // MCU write while idle.
        @(negedge CLK);
        CPU_WE = 1'b1; CPU_WA = 13'h0ABC; CPU_WD = 8'hA5;
        @(negedge CLK);
        CPU_WE = 1'b0;
        @(negedge CLK);
        check("idle_cpu_busy", 32'(BUSY), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Full-screen fill interrupted by reset after ~100 writes.
        base = fill_seen;
        push_rect(7'd0, 6'd0, 7'd79, 6'd59, 8'h3C);
        @(negedge CLK);
        X0 = 7'd0; Y0 = 6'd0; X1 = 7'd79; Y1 = 6'd59; COLOR = 8'h3C;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cnt = 0;
        while (cnt < 1000 && (fill_seen - base) < 100) begin
            @(negedge CLK);
            cnt++;
        end
        check("full_fill_progress", 32'((fill_seen - base) >= 100), 32'd1);
        check("full_fill_busy", 32'(BUSY), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("midrst_WE", 32'(WE), 32'd0);
        check("midrst_WA", 32'(WA), 32'd0);
        check("midrst_WD", 32'(WD), 32'd0);
        check("midrst_BUSY", 32'(BUSY), 32'd0);
        check("midrst_DONE", 32'(DONE), 32'd0);
        $display("reset after %0d fill writes", fill_seen - base);
        fill_q.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        base = fill_seen;
        repeat (20) @(negedge CLK);
        check("post_rst_no_fill", 32'(fill_seen - base), 32'd0);
        check("post_rst_busy", 32'(BUSY), 32'd0);

        run_vec(5, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
